// File: rtl/pixel_packetizer.sv
// pixel_packetizer
//   Buffers the 8-bit pixel stream from the capture stage in a FIFO and emits
//   packets of {4-byte header, PAYLOAD_BYTES pixels} on a valid/ready byte
//   stream towards the UDP TX builder.
//   Header = {frame_id[15:8], frame_id[7:0], pkt_id[15:8], pkt_id[7:0]}.
//
// Optional build macro: PKTZ_CHECKSUM_EN
//   When defined, a fifth trailer byte (XOR of the payload bytes) follows the
//   payload and carries tx_eop.
//
// Ports
//   clk          single clock for pixel, frame and TX interfaces
//   rst          synchronous, active-high reset
//   frame_start  1-cycle pulse at frame start
//   pixel        pixel byte, qualified by pixel_valid
//   pixel_valid  pixel qualifier
//   out_ready    registered flow control: free entries >= READY_MARGIN
//   tx_data      stream byte, qualified by tx_valid
//   tx_valid     tx_data valid
//   tx_ready     sink accepts the byte this cycle
//   tx_sop       first header byte of a packet
//   tx_eop       last byte of a packet
//   overflow     sticky: a pixel was dropped on a full FIFO
module pixel_packetizer #(
  parameter int PAYLOAD_BYTES = 1024,
  parameter int FIFO_DEPTH    = 4096,
  parameter int FRAME_BYTES   = 307200,
  parameter int READY_MARGIN  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [7:0] pixel,
  input  logic       pixel_valid,
  output logic       out_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_sop,
  output logic       tx_eop,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(PAYLOAD_BYTES);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PAY_C    = CW'(PAYLOAD_BYTES);
  localparam logic [CW-1:0] MARGIN_C = CW'(READY_MARGIN);
  localparam logic [15:0]   LAST_PKT = 16'(FRAME_BYTES / PAYLOAD_BYTES - 1);

`ifdef PKTZ_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_CHK} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY} state_t;
`endif

  state_t          state_q, state_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [15:0]     frame_id_q, frame_id_d;
  logic [15:0]     pkt_id_q, pkt_id_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            out_ready_q, out_ready_d;
`ifdef PKTZ_CHECKSUM_EN
  logic [7:0]      acc_q, acc_d;
`endif
  logic [7:0]      mem [FIFO_DEPTH];
  logic [7:0]      rd_data_q;
  logic            push, pop, pkt_done, pay_last;

  // FIFO bookkeeping
  always_comb begin
    push        = pixel_valid && (count_q != DEPTH_C);
    pop         = (state_q == ST_PAY) && tx_ready;
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    overflow_d  = overflow_q | (pixel_valid & ~push);
    out_ready_d = (DEPTH_C - count_q) >= MARGIN_C;
  end

  // Block RAM with registered read. The read address is the post-pop pointer,
  // so rd_data_q always shows the current FIFO head one cycle later; the head
  // is re-read every cycle, which also covers a write landing on it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= pixel;
    rd_data_q <= mem[rd_ptr_d];
  end

  // Packet FSM and stream outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_id_d = frame_id_q;
    pkt_id_d   = pkt_id_q;
    pend_d     = pend_q;
`ifdef PKTZ_CHECKSUM_EN
    acc_d      = acc_q;
`endif
    pkt_done   = 1'b0;
    tx_valid   = 1'b0;
    tx_sop     = 1'b0;
    tx_eop     = 1'b0;
    tx_data    = 8'h00;
    pay_last   = (cnt_q == {BW{1'b1}});

    case (state_q)
      ST_IDLE: begin
        // frame_start takes effect before a header decided this same cycle
        if (frame_start) begin
          frame_id_d = frame_id_q + 16'd1;
          pkt_id_d   = 16'd0;
        end
        if (count_q >= PAY_C) begin
          state_d = ST_HDR;
          cnt_d   = '0;
`ifdef PKTZ_CHECKSUM_EN
          acc_d   = 8'h00;
`endif
        end
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_sop   = (cnt_q[1:0] == 2'd0);
        case (cnt_q[1:0])
          2'd0:    tx_data = frame_id_q[15:8];
          2'd1:    tx_data = frame_id_q[7:0];
          2'd2:    tx_data = pkt_id_q[15:8];
          default: tx_data = pkt_id_q[7:0];
        endcase
        if (tx_ready) begin
          if (cnt_q[1:0] == 2'd3) begin
            state_d = ST_PAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
      ST_PAY: begin
        tx_valid = 1'b1;
        tx_data  = rd_data_q;
`ifndef PKTZ_CHECKSUM_EN
        tx_eop   = pay_last;
`endif
        if (tx_ready) begin
          cnt_d = cnt_q + BW'(1);
`ifdef PKTZ_CHECKSUM_EN
          acc_d = acc_q ^ rd_data_q;
          if (pay_last) state_d = ST_CHK;
`else
          if (pay_last) pkt_done = 1'b1;
`endif
        end
      end
`ifdef PKTZ_CHECKSUM_EN
      ST_CHK: begin
        tx_valid = 1'b1;
        tx_data  = acc_q;
        tx_eop   = 1'b1;
        if (tx_ready) pkt_done = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && frame_start) pend_d = 1'b1;

    // End of packet counts as IDLE entry; if the next payload is already
    // buffered go straight to the next header so there is no bubble.
    if (pkt_done) begin
      if (pend_d) begin
        frame_id_d = frame_id_q + 16'd1;
        pkt_id_d   = 16'd0;
        pend_d     = 1'b0;
      end else if (pkt_id_q == LAST_PKT) begin
        pkt_id_d = 16'd0;
      end else begin
        pkt_id_d = pkt_id_q + 16'd1;
      end
      if (count_d >= PAY_C) begin
        state_d = ST_HDR;
        cnt_d   = '0;
`ifdef PKTZ_CHECKSUM_EN
        acc_d   = 8'h00;
`endif
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frame_id_q  <= 16'd0;
      pkt_id_q    <= 16'd0;
      pend_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      out_ready_q <= 1'b0;
`ifdef PKTZ_CHECKSUM_EN
      acc_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_id_q  <= frame_id_d;
      pkt_id_q    <= pkt_id_d;
      pend_q      <= pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      out_ready_q <= out_ready_d;
`ifdef PKTZ_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign out_ready = out_ready_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pixel_packetizer.sv
// Testbench for pixel_packetizer (small configuration: 16-byte payload,
// 64-entry FIFO, 64-byte frame). Expected stream bytes are queued as pixels
// are driven and compared as the DUT presents them.
module tb_pixel_packetizer;

  localparam int PAY    = 16;
  localparam int DEPTH  = 64;
  localparam int FRAME  = 64;
  localparam int MARGIN = 16;
  localparam int PKTS   = FRAME / PAY;
`ifdef PKTZ_CHECKSUM_EN
  localparam int PKT_LEN = PAY + 5;
`else
  localparam int PKT_LEN = PAY + 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic [7:0] pixel = 8'h00;
  logic       pixel_valid = 1'b0;
  logic       out_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       tx_sop;
  logic       tx_eop;
  logic       overflow;

  pixel_packetizer #(
    .PAYLOAD_BYTES(PAY),
    .FIFO_DEPTH   (DEPTH),
    .FRAME_BYTES  (FRAME),
    .READY_MARGIN (MARGIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pixel      (pixel),
    .pixel_valid(pixel_valid),
    .out_ready  (out_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_sop     (tx_sop),
    .tx_eop     (tx_eop),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  sb[$];        // {sop, eop, data}
  logic [7:0]  pay_buf[$];
  logic [15:0] m_frame = 16'd0;
  logic [15:0] m_pkt   = 16'd0;
  bit          mon_en = 1'b0;
  bit          toggle_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Queue one full packet built from pay_buf and advance the id model
  task automatic push_packet();
    logic [7:0] acc;
    acc = 8'h00;
    sb.push_back({1'b1, 1'b0, m_frame[15:8]});
    sb.push_back({1'b0, 1'b0, m_frame[7:0]});
    sb.push_back({1'b0, 1'b0, m_pkt[15:8]});
    sb.push_back({1'b0, 1'b0, m_pkt[7:0]});
    for (int i = 0; i < PAY; i++) begin
      acc = acc ^ pay_buf[i];
`ifdef PKTZ_CHECKSUM_EN
      sb.push_back({1'b0, 1'b0, pay_buf[i]});
`else
      sb.push_back({1'b0, (i == PAY - 1), pay_buf[i]});
`endif
    end
`ifdef PKTZ_CHECKSUM_EN
    sb.push_back({1'b0, 1'b1, acc});
`endif
    m_pkt = (m_pkt == 16'(PKTS - 1)) ? 16'd0 : m_pkt + 16'd1;
    pay_buf.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) tx_ready = ~tx_ready;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int n, input logic [7:0] base, input bit drop);
    for (int i = 0; i < n; i++) begin
      pixel       = base + 8'(i);
      pixel_valid = 1'b1;
      if (!drop) begin
        pay_buf.push_back(pixel);
        if (pay_buf.size() == PAY) push_packet();
      end
      tick();
    end
    pixel_valid = 1'b0;
  endtask

  // frame_start applies to the next packet not yet queued
  task automatic frame_pulse();
    frame_start = 1'b1;
    m_frame     = m_frame + 16'd1;
    m_pkt       = 16'd0;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, sb.size(), 0);
    idle(2);
  endtask

  // Wait until the DUT is part-way through a payload
  task automatic wait_pay(input string tag);
    int k;
    k = 0;
    while (sb.size() > PKT_LEN - 8 && k < 200) begin
      tick();
      k++;
    end
    check(tag, (sb.size() <= PKT_LEN - 8), 1);
  endtask

  // Stream monitor: a presented byte must match the queue head, whether it
  // transfers this cycle or is being held by a stall.
  always @(negedge clk) begin
    if (mon_en && !rst && tx_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", {tx_sop, tx_eop, tx_data}, 10'h3ff);
      end else if (tx_ready) begin
        check("xfer", {tx_sop, tx_eop, tx_data}, sb[0]);
        void'(sb.pop_front());
      end else begin
        check("stall", {tx_sop, tx_eop, tx_data}, sb[0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset state
    idle(3);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_sop", tx_sop, 0);
    check("rst_tx_eop", tx_eop, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_ready", out_ready, 0);
    rst = 1'b0;
    idle(2);
    check("out_ready_empty", out_ready, 1);
    mon_en = 1'b1;

    // T1: frame_start then 16 pixels, sink always ready
    tx_ready = 1'b1;
    frame_pulse();
    send(16, 8'h00, 1'b0);
    wait_drain("t1_drain", 100);

    // T2: same stream with tx_ready toggling every cycle
    toggle_en = 1'b1;
    send(16, 8'h00, 1'b0);
    wait_drain("t2_drain", 200);
    toggle_en = 1'b0;
    tx_ready  = 1'b1;

    // T3: sink stalled, FIFO_DEPTH+3 pixels, out_ready boundary and drops
    tx_ready = 1'b0;
    send(48, 8'h40, 1'b0);
    idle(2);
    check("t3_out_ready_free16", out_ready, 1);
    send(1, 8'h70, 1'b0);
    idle(2);
    check("t3_out_ready_free15", out_ready, 0);
    send(15, 8'h71, 1'b0);
    idle(2);
    check("t3_overflow_before", overflow, 0);
    check("t3_out_ready_full", out_ready, 0);
    send(3, 8'hF0, 1'b1);
    idle(2);
    check("t3_overflow_set", overflow, 1);
    tx_ready = 1'b1;
    wait_drain("t3_drain", 400);
    check("t3_overflow_sticky", overflow, 1);

    // T4: frame_start during the payload of pkt_id 2
    check("t4_model_pkt", m_pkt, 2);
    send(16, 8'h10, 1'b0);
    wait_pay("t4_reach_pay");
    frame_pulse();
    send(16, 8'h20, 1'b0);
    wait_drain("t4_drain", 200);

    // T5: five packets without frame_start, back-to-back at full rate
    tx_ready = 1'b0;
    send(64, 8'h80, 1'b0);
    tx_ready = 1'b1;
    cyc = 0;
    while (cyc < 400) begin
      if (cyc >= 8 && cyc < 24) begin
        pixel       = 8'hC0 + 8'(cyc - 8);
        pixel_valid = 1'b1;
        pay_buf.push_back(pixel);
        if (pay_buf.size() == PAY) push_packet();
      end else begin
        pixel_valid = 1'b0;
      end
      tick();
      cyc++;
      if (cyc >= 24 && sb.size() == 0) break;
    end
    pixel_valid = 1'b0;
    check("t5_cycles", cyc, 5 * PKT_LEN);
    idle(2);

    // T6: reset in the middle of a payload
    send(16, 8'hD0, 1'b0);
    wait_pay("t6_reach_pay");
    mon_en = 1'b0;
    rst    = 1'b1;
    tick();
    check("t6_tx_valid", tx_valid, 0);
    check("t6_overflow", overflow, 0);
    check("t6_out_ready", out_ready, 0);
    sb.delete();
    pay_buf.delete();
    m_frame = 16'd0;
    m_pkt   = 16'd0;
    rst     = 1'b0;
    idle(2);
    mon_en = 1'b1;
    send(16, 8'hA0, 1'b0);
    wait_drain("t6_drain", 100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
